// File: rtl/code_conv_pkg.sv
// Shared code-mode constants and FSM encoding for the coded-digit stream decoder.
package code_conv_pkg;

    localparam logic [1:0] MODE_BCD  = 2'b00;
    localparam logic [1:0] MODE_XS3  = 2'b01;
    localparam logic [1:0] MODE_GRAY = 2'b10;
    localparam logic [1:0] MODE_RSVD = 2'b11;

    localparam logic [3:0] XS3_OFFSET = 4'd3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCUM,
        ST_DRAIN,
        ST_DONE
    } state_e;

endpackage

// File: rtl/code_stream_decoder_digit_decode.sv
// Combinational per-digit decode: maps a 4-bit code to a decimal digit and flags illegal codes.
module digit_decode
    import code_conv_pkg::*;
(
    input  logic [1:0] mode,
    input  logic [3:0] code,
    output logic [3:0] digit,
    output logic       ok
);

    logic [3:0] gray_bin;

    always_comb begin
        gray_bin[3] = code[3];
        gray_bin[2] = gray_bin[3] ^ code[2];
        gray_bin[1] = gray_bin[2] ^ code[1];
        gray_bin[0] = gray_bin[1] ^ code[0];
    end

    // Illegal codes report digit 0 so they contribute nothing to the accumulator.
    always_comb begin
        digit = '0;
        ok    = 1'b0;
        case (mode)
            MODE_BCD: begin
                ok    = (code <= 4'd9);
                digit = ok ? code : '0;
            end
            MODE_XS3: begin
                ok    = (code >= XS3_OFFSET) && (code <= 4'd12);
                digit = ok ? (code - XS3_OFFSET) : '0;
            end
            MODE_GRAY: begin
                ok    = (gray_bin <= 4'd9);
                digit = ok ? gray_bin : '0;
            end
            default: begin
                ok    = 1'b0;
                digit = '0;
            end
        endcase
    end

endmodule

// File: rtl/code_stream_decoder.sv
// Multi-digit coded-decimal stream decoder: accumulates MSD-first digits into a binary value.
module code_stream_decoder
    import code_conv_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned OUT_W      = 14,
    parameter int unsigned CNT_W      = $clog2(NUM_DIGITS + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       mode,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_digit,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_value,
    output logic             out_error,
    output logic [CNT_W-1:0] out_count
);

    state_e             state_q, state_d;
    logic [1:0]         mode_q, mode_d;
    logic [OUT_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               err_q, err_d;

    logic [3:0]         dig;
    logic               dig_ok;
    logic [OUT_W-1:0]   dig_ext;

    digit_decode u_digit_decode (
        .mode  (mode_q),
        .code  (in_digit),
        .digit (dig),
        .ok    (dig_ok)
    );

    assign dig_ext = OUT_W'(dig);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            mode_q  <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    mode_d  = mode;
                    acc_d   = '0;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    state_d = ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                if (in_valid) begin
                    acc_d = (acc_q << 3) + (acc_q << 1) + dig_ext;
                    cnt_d = cnt_q + 1'b1;
                    err_d = err_q | ~dig_ok;
                    if (in_last) begin
                        state_d = ST_DONE;
                    end else if (cnt_d == CNT_W'(NUM_DIGITS)) begin
                        err_d   = 1'b1;
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                // Excess digits are consumed to keep the stream aligned, but not accumulated.
                if (in_valid && in_last) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign in_ready  = (state_q == ST_ACCUM) || (state_q == ST_DRAIN);
    assign out_valid = (state_q == ST_DONE);
    assign out_value = acc_q;
    assign out_error = err_q;
    assign out_count = cnt_q;

endmodule

// File: tb/tb_code_stream_decoder.sv
// Directed scoreboard bench for code_stream_decoder.
module tb_code_stream_decoder;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  mode;
    logic        start;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_digit;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [13:0] out_value;
    logic        out_error;
    logic [2:0]  out_count;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int value;
        int err;
        int count;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    code_stream_decoder #(
        .NUM_DIGITS (4),
        .OUT_W      (14),
        .CNT_W      (3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode),
        .start     (start),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_digit  (in_digit),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_value (out_value),
        .out_error (out_error),
        .out_count (out_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input int v, input int e, input int c);
        exp_t x;
        x.value = v;
        x.err   = e;
        x.count = c;
        sb.push_back(x);
    endtask

    // Digits are packed LSB-nibble first: digs[3:0] is the first (most significant) digit.
    task automatic send_frame(input logic [1:0] m, input int n, input logic [31:0] digs,
                              input bit with_last);
        start = 1'b1;
        mode  = m;
        check("in_ready_idle", 32'(in_ready), 0);
        step();
        start = 1'b0;
        mode  = 2'b00;
        check("in_ready_accum", 32'(in_ready), 1);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_digit = digs[i*4 +: 4];
            in_last  = with_last && (i == n - 1);
            step();
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_digit = '0;
        if (with_last) check("out_valid_latency", 32'(out_valid), 1);
    endtask

    task automatic collect(input string tag);
        exp_t e;
        int   k = 0;
        while (!out_valid && k < 20) begin
            step();
            k++;
        end
        check({tag, "_valid"}, 32'(out_valid), 1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check({tag, "_value"}, 32'(out_value), e.value);
            check({tag, "_error"}, 32'(out_error), e.err);
            check({tag, "_count"}, 32'(out_count), e.count);
        end else begin
            check({tag, "_scoreboard_empty"}, 0, 1);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check({tag, "_valid_drop"}, 32'(out_valid), 0);
    endtask

    initial begin
        rst       = 1'b1;
        mode      = '0;
        start     = 1'b0;
        in_valid  = 1'b0;
        in_digit  = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        step();
        step();
        check("rst_in_ready",  32'(in_ready),  0);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_value", 32'(out_value), 0);
        check("rst_out_error", 32'(out_error), 0);
        check("rst_out_count", 32'(out_count), 0);
        rst = 1'b0;
        step();

        push_exp(1234, 0, 4);
        send_frame(2'b00, 4, 32'h4321, 1'b1);
        collect("bcd");

        push_exp(90, 0, 2);
        send_frame(2'b01, 2, 32'h3C, 1'b1);
        collect("xs3");

        push_exp(2, 1, 2);
        send_frame(2'b01, 2, 32'h52, 1'b1);
        collect("xs3_bad");

        push_exp(129, 0, 4);
        send_frame(2'b10, 4, 32'hD310, 1'b1);
        collect("gray");

        push_exp(10, 1, 2);
        send_frame(2'b10, 2, 32'hF1, 1'b1);
        collect("gray_bad");

        push_exp(105, 1, 3);
        send_frame(2'b00, 3, 32'h5A1, 1'b1);
        collect("bcd_bad");

        push_exp(1234, 1, 4);
        send_frame(2'b00, 6, 32'h654321, 1'b1);
        collect("overlength");

        push_exp(78, 0, 2);
        send_frame(2'b00, 2, 32'h87, 1'b1);
        collect("after_overlength");

        push_exp(0, 1, 1);
        send_frame(2'b11, 1, 32'h5, 1'b1);
        collect("reserved");

        push_exp(79, 0, 2);
        send_frame(2'b00, 2, 32'h97, 1'b1);
        for (int c = 0; c < 3; c++) begin
            start = (c == 0);
            mode  = 2'b01;
            step();
            check("bp_valid", 32'(out_valid), 1);
            check("bp_value", 32'(out_value), 79);
            check("bp_error", 32'(out_error), 0);
            check("bp_count", 32'(out_count), 2);
        end
        start = 1'b0;
        mode  = 2'b00;
        collect("backpressure");
        check("bp_start_ignored", 32'(in_ready), 0);

        send_frame(2'b00, 2, 32'h21, 1'b0);
        check("mid_in_ready", 32'(in_ready), 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mr_in_ready",  32'(in_ready),  0);
        check("mr_out_valid", 32'(out_valid), 0);
        check("mr_out_value", 32'(out_value), 0);
        check("mr_out_error", 32'(out_error), 0);
        check("mr_out_count", 32'(out_count), 0);
        step();
        check("mr_stay_idle", 32'(out_valid), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
